histogram_cdf_pingpong: RTL

//  Parametrised successor to the single-frame greyscale histogram unit. Bins streaming Grey pixels

---
 rtl/histogram_cdf_pingpong.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/histogram_cdf_pingpong.sv
// Streaming greyscale histogram with ping-pong count banks and a per-frame
// cumulative pass; the completed frame is exposed on a random-access read port.
module histogram_cdf_pingpong #(
  parameter int PIX_W    = 12,
  parameter int BIN_BITS = 8,
  parameter int CNT_W    = 20
) (
  input  logic                iPclk,
  input  logic                iRST_N,
  input  logic                iFval,
  input  logic                iDval,
  input  logic [PIX_W-1:0]    iGrey,
  input  logic [BIN_BITS-1:0] iRd_Addr,
  output logic [CNT_W-1:0]    oHist,
  output logic [CNT_W-1:0]    oCum,
  output logic [CNT_W-1:0]    oTotal,
  output logic                oRd_Valid,
  output logic                oFrame_Done,
  output logic                oOverrun
);

  localparam int NUM_BINS = 1 << BIN_BITS;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_CDF   = 3'd4;

  localparam logic [BIN_BITS-1:0] LAST = '1;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] x
  );
    return (&x) ? x : x + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] bank0_q [NUM_BINS];
  logic [CNT_W-1:0] bank1_q [NUM_BINS];
  logic [CNT_W-1:0] cum_q   [NUM_BINS];

  logic [2:0]          state_q, state_d;
  logic [BIN_BITS-1:0] cnt_q, cnt_d;
  logic                wsel_q, wsel_d;
  logic                rsel_q, rsel_d;
  logic                fval_q;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    tot_q, tot_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic [CNT_W-1:0]    hist_q, hist_d;
  logic [CNT_W-1:0]    ocum_q, ocum_d;

  logic                v1_q, v2_q, v3_q;
  logic [BIN_BITS-1:0] b1_q, b2_q, b3_q;
  logic [CNT_W-1:0]    c2_q, c2_d;
  logic [CNT_W-1:0]    n3_q;

  logic                rise, fall, samp;
  logic [BIN_BITS-1:0] bin_in, rd_idx;
  logic [CNT_W-1:0]    rd_w, acc_sum;
  logic                unused_grey;

  assign unused_grey = ^iGrey;

  assign rise   = iFval & ~fval_q;
  assign fall   = ~iFval & fval_q;
  assign bin_in = iGrey[PIX_W-1 -: BIN_BITS];
  assign samp   = iFval & iDval &
                  ((state_q == S_ACCUM) |
                   ((state_q == S_IDLE) & rise));

  assign rd_idx  = (state_q == S_CDF) ? cnt_q : b1_q;
  assign rd_w    = wsel_q ? bank1_q[rd_idx] : bank0_q[rd_idx];
  assign acc_sum = sat_add(acc_q, rd_w);

  // Newest in-flight count for the same bin wins over the bank contents
  always_comb begin
    c2_d = rd_w;
    if (v2_q && (b2_q == b1_q)) begin
      c2_d = sat_inc(c2_q);
    end else if (v3_q && (b3_q == b1_q)) begin
      c2_d = n3_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    acc_d   = acc_q;
    tot_d   = samp ? sat_inc(tot_q) : tot_q;
    total_d = total_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    hist_d  = rsel_q ? bank1_q[iRd_Addr] : bank0_q[iRd_Addr];
    ocum_d  = cum_q[iRd_Addr];
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (rise) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        ovr_d = rise;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q[0]) begin
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = S_CDF;
        end
      end
      S_CDF: begin
        ovr_d = rise;
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          rsel_d  = wsel_q;
          wsel_d  = ~wsel_q;
          total_d = tot_q;
          valid_d = 1'b1;
          done_d  = 1'b1;
          acc_d   = '0;
          tot_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b1;
      fval_q  <= 1'b0;
      acc_q   <= '0;
      tot_q   <= '0;
      total_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      hist_q  <= '0;
      ocum_q  <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      b1_q    <= '0;
      b2_q    <= '0;
      b3_q    <= '0;
      c2_q    <= '0;
      n3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      fval_q  <= iFval;
      acc_q   <= acc_d;
      tot_q   <= tot_d;
      total_q <= total_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      hist_q  <= hist_d;
      ocum_q  <= ocum_d;
      v1_q    <= samp;
      b1_q    <= bin_in;
      v2_q    <= v1_q;
      b2_q    <= b1_q;
      c2_q    <= c2_d;
      v3_q    <= v2_q;
      b3_q    <= b2_q;
      n3_q    <= sat_inc(c2_q);
    end
  end

  // CDF pass clears the old readout bank so it is empty when it becomes the write bank
  always_ff @(posedge iPclk) begin
    if (state_q == S_INIT) begin
      bank0_q[cnt_q] <= '0;
      bank1_q[cnt_q] <= '0;
      cum_q[cnt_q]   <= '0;
    end
    if (v3_q) begin
      if (wsel_q) bank1_q[b3_q] <= n3_q;
      else        bank0_q[b3_q] <= n3_q;
    end
    if (state_q == S_CDF) begin
      cum_q[cnt_q] <= acc_sum;
      if (wsel_q) bank0_q[cnt_q] <= '0;
      else        bank1_q[cnt_q] <= '0;
    end
  end

  assign oHist       = hist_q;
  assign oCum        = ocum_q;
  assign oTotal      = total_q;
  assign oRd_Valid   = valid_q;
  assign oFrame_Done = done_q;
  assign oOverrun    = ovr_q;

endmodule
